// File: rtl/pulse_sequencer.sv
// RF pulse-sequence generator: dead time, RF pulses, free evolution and a readout gate,
// repeated for a latched number of shots. Covers the Rabi, Ramsey and Hahn-echo sequences.
module pulse_sequencer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] dead_cnt,
  input  logic [CNT_W-1:0] pi2_cnt,
  input  logic [CNT_W-1:0] tau_cnt,
  input  logic [CNT_W-1:0] read_cnt,
  input  logic [REP_W-1:0] n_shots,
  output logic             rf,
  output logic             readout,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] shot_idx
);

  localparam int unsigned LEN_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DEAD, S_P1, S_T1, S_PI, S_T2, S_P2, S_READ
  } state_t;

  typedef enum logic [1:0] {
    M_RABI, M_RAMSEY, M_ECHO, M_RSVD
  } mode_t;

  state_t             state_q, state_d;
  state_t             nxt;
  mode_t              mode_q, mode_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   nxt_len;
  logic [CNT_W-1:0]   dead_q, dead_d;
  logic [CNT_W-1:0]   pi2_q, pi2_d;
  logic [CNT_W-1:0]   tau_q, tau_d;
  logic [CNT_W-1:0]   read_q, read_d;
  logic [REP_W-1:0]   shots_q, shots_d;
  logic [REP_W-1:0]   shot_idx_q, shot_idx_d;
  logic               trig_q, trig_d;
  logic               rf_q, rf_d;
  logic               readout_q, readout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start;
  logic               last_shot;
  logic               has_tau;

  // Phase counter holds (length - 1); a zero length still occupies one cycle.
  function automatic logic [LEN_W-1:0] load_val(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_W'(1);
  endfunction

  assign start     = trig && !trig_q && (state_q == S_IDLE) && !abort;
  // One extra bit keeps shot_idx+1 exact; n_shots = 0 compares as a single shot.
  assign last_shot = ({1'b0, shot_idx_q} + (REP_W+1)'(1)) >= {1'b0, shots_q};
  assign has_tau   = (mode_q == M_RAMSEY) || (mode_q == M_ECHO);

  always_comb begin
    nxt = S_IDLE;
    case (state_q)
      S_DEAD:  nxt = S_P1;
      S_P1:    nxt = has_tau ? S_T1 : S_READ;
      S_T1:    nxt = (mode_q == M_ECHO) ? S_PI : S_P2;
      S_PI:    nxt = S_T2;
      S_T2:    nxt = S_P2;
      S_P2:    nxt = S_READ;
      S_READ:  nxt = last_shot ? S_IDLE : S_DEAD;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nxt_len = '0;
    case (nxt)
      S_DEAD:       nxt_len = {1'b0, dead_q};
      S_P1, S_P2:   nxt_len = {1'b0, pi2_q};
      S_T1, S_T2:   nxt_len = {1'b0, tau_q};
      S_PI:         nxt_len = {pi2_q, 1'b0};
      S_READ:       nxt_len = {1'b0, read_q};
      default:      nxt_len = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    dead_d     = dead_q;
    pi2_d      = pi2_q;
    tau_d      = tau_q;
    read_d     = read_q;
    shots_d    = shots_q;
    shot_idx_d = shot_idx_q;
    trig_d     = trig;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      if (start) begin
        mode_d     = mode_t'(mode);
        dead_d     = dead_cnt;
        pi2_d      = pi2_cnt;
        tau_d      = tau_cnt;
        read_d     = read_cnt;
        shots_d    = n_shots;
        shot_idx_d = '0;
        state_d    = S_DEAD;
        cnt_d      = load_val({1'b0, dead_cnt});
      end
    end else if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end else begin
      state_d = nxt;
      cnt_d   = load_val(nxt_len);
      if (state_q == S_READ) begin
        if (last_shot) begin
          done_d = 1'b1;
        end else begin
          shot_idx_d = shot_idx_q + REP_W'(1);
        end
      end
    end

    rf_d      = (state_d == S_P1) || (state_d == S_PI) || (state_d == S_P2);
    readout_d = (state_d == S_READ);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= M_RABI;
      dead_q     <= '0;
      pi2_q      <= '0;
      tau_q      <= '0;
      read_q     <= '0;
      shots_q    <= '0;
      shot_idx_q <= '0;
      trig_q     <= 1'b0;
      rf_q       <= 1'b0;
      readout_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      dead_q     <= dead_d;
      pi2_q      <= pi2_d;
      tau_q      <= tau_d;
      read_q     <= read_d;
      shots_q    <= shots_d;
      shot_idx_q <= shot_idx_d;
      trig_q     <= trig_d;
      rf_q       <= rf_d;
      readout_q  <= readout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rf       = rf_q;
  assign readout  = readout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign shot_idx = shot_idx_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: per-cycle comparison of busy/rf/readout/done/shot_idx
// against hand-listed phase sequences.
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] dead_cnt = '0;
  logic [31:0] pi2_cnt = '0;
  logic [31:0] tau_cnt = '0;
  logic [31:0] read_cnt = '0;
  logic [15:0] n_shots = '0;
  logic        rf, readout, busy, done;
  logic [15:0] shot_idx;

  int n_checks = 0;
  int n_pass   = 0;

  bit e_rf[$];
  bit e_rd[$];
  int e_idx[$];

  pulse_sequencer #(.CNT_W(32), .REP_W(16)) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort), .mode(mode),
    .dead_cnt(dead_cnt), .pi2_cnt(pi2_cnt), .tau_cnt(tau_cnt), .read_cnt(read_cnt),
    .n_shots(n_shots), .rf(rf), .readout(readout), .busy(busy), .done(done),
    .shot_idx(shot_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Observed vector: {busy, rf, readout, done, shot_idx}
  function automatic logic [19:0] obs();
    return {busy, rf, readout, done, shot_idx};
  endfunction

  function automatic logic [19:0] vec(input bit b, input bit r, input bit rd, input bit d, input int idx);
    return {b, r, rd, d, 16'(idx)};
  endfunction

  task automatic clr();
    e_rf.delete(); e_rd.delete(); e_idx.delete();
  endtask

  task automatic seg(input bit r, input bit rd, input int len, input int idx);
    int n;
    n = (len == 0) ? 1 : len;
    repeat (n) begin
      e_rf.push_back(r); e_rd.push_back(rd); e_idx.push_back(idx);
    end
  endtask

  task automatic shot(input int m, input int dd, input int p, input int t, input int rd, input int idx);
    seg(0, 0, dd, idx);
    seg(1, 0, p, idx);
    if (m == 1 || m == 2) seg(0, 0, t, idx);
    if (m == 2) begin
      seg(1, 0, 2 * p, idx);
      seg(0, 0, t, idx);
    end
    if (m == 1 || m == 2) seg(1, 0, p, idx);
    seg(0, 1, rd, idx);
  endtask

  task automatic setup(input int m, input int dd, input int p, input int t, input int rd, input int ns);
    mode = 2'(m); dead_cnt = dd; pi2_cnt = p; tau_cnt = t; read_cnt = rd; n_shots = 16'(ns);
  endtask

  // Raise trig and compare up to ncyc cycles of the expected sequence; if ncyc exceeds it,
  // also check the done cycle and the idle cycle after it.
  task automatic play(input string name, input int ncyc, input bit noise);
    int len;
    len = e_rf.size();
    trig = 1'b1;
    tick();
    for (int j = 0; j < len && j < ncyc; j++) begin
      check($sformatf("%s cyc%0d", name, j), obs(), vec(1, e_rf[j], e_rd[j], 0, e_idx[j]));
      if (noise) begin
        trig     = (j < len - 3) ? ((j % 2) == 1) : 1'b0;
        mode     = 2'($urandom);
        dead_cnt = $urandom_range(0, 20);
        pi2_cnt  = $urandom_range(0, 20);
        tau_cnt  = $urandom_range(0, 20);
        read_cnt = $urandom_range(0, 20);
        n_shots  = 16'($urandom_range(0, 5));
      end
      if (j + 1 < ncyc) tick();
    end
    if (ncyc > len) begin
      check({name, " done"}, obs(), vec(0, 0, 0, 1, e_idx[len-1]));
      trig = 1'b0;
      tick();
      check({name, " post"}, obs(), vec(0, 0, 0, 0, e_idx[len-1]));
    end
  endtask

  initial begin
    tick(); tick();
    check("reset", obs(), vec(0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    check("idle", obs(), vec(0, 0, 0, 0, 0));

    // Rabi: busy k..k+11, rf k+5..k+7, readout k+8..k+11, done at k+12
    setup(0, 5, 3, 9, 4, 1); clr(); shot(0, 5, 3, 9, 4, 0);
    play("rabi", 1000, 0);

    setup(1, 2, 2, 10, 3, 1); clr(); shot(1, 2, 2, 10, 3, 0);
    play("ramsey", 1000, 0);

    setup(2, 3, 4, 6, 2, 1); clr(); shot(2, 3, 4, 6, 2, 0);
    play("echo", 1000, 0);

    setup(0, 2, 1, 7, 2, 3); clr();
    for (int s = 0; s < 3; s++) shot(0, 2, 1, 7, 2, s);
    play("shots3", 1000, 0);

    setup(0, 0, 0, 0, 0, 0); clr(); shot(0, 0, 0, 0, 0, 0);
    play("zero", 1000, 0);

    setup(2, 0, 0, 0, 0, 1); clr(); shot(2, 0, 0, 0, 0, 0);
    play("echo_zero", 1000, 0);

    setup(3, 1, 2, 5, 1, 1); clr(); shot(0, 1, 2, 5, 1, 0);
    play("mode3", 1000, 0);

    // Abort in PI (PI spans cycles 7..12 here); trig stays high afterwards
    setup(2, 2, 3, 2, 2, 1); clr(); shot(2, 2, 3, 2, 2, 0);
    play("abort_pre", 9, 0);
    abort = 1'b1;
    tick();
    check("abort edge", obs(), vec(0, 0, 0, 0, 0));
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort hold%0d", i), obs(), vec(0, 0, 0, 0, 0));
    end
    trig = 1'b0;
    tick();
    play("after_abort", 1000, 0);

    // abort together with a trig edge in IDLE: no start
    trig = 1'b1; abort = 1'b1;
    tick();
    check("abort+trig", obs(), vec(0, 0, 0, 0, 0));
    abort = 1'b0;
    tick();
    check("trig held", obs(), vec(0, 0, 0, 0, 0));
    trig = 1'b0;
    tick();

    // Reset in T1 of the second shot (shot1 spans 12..23, T1 at 16..19)
    setup(1, 2, 2, 4, 2, 2); clr(); shot(1, 2, 2, 4, 2, 0); shot(1, 2, 2, 4, 2, 1);
    play("rst_pre", 18, 0);
    rst = 1'b1; trig = 1'b0;
    tick();
    check("rst mid", obs(), vec(0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    check("rst after", obs(), vec(0, 0, 0, 0, 0));
    tick();
    check("rst quiet", obs(), vec(0, 0, 0, 0, 0));

    // Trig pulses and input changes while busy do not disturb the run
    setup(2, 2, 2, 3, 2, 2); clr(); shot(2, 2, 2, 3, 2, 0); shot(2, 2, 2, 3, 2, 1);
    play("noise", 1000, 1);

    // Back-to-back: restart on the cycle right after done
    setup(0, 1, 1, 1, 1, 1); clr(); shot(0, 1, 1, 1, 1, 0);
    trig = 1'b1; tick();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("b2b_a cyc%0d", j), obs(), vec(1, e_rf[j], e_rd[j], 0, 0));
      if (j == 2) trig = 1'b0;
      tick();
    end
    check("b2b_a done", obs(), vec(0, 0, 0, 1, 0));
    trig = 1'b1;
    tick();
    check("b2b_b start", obs(), vec(1, 0, 0, 0, 0));
    trig = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("b2b_b done", obs(), vec(0, 0, 0, 1, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
